// File: rtl/tx_pkt_segmenter.sv
// Send-queue packet segmenter: splits one WQE at a time into MTU-sized packet
// descriptors, then writes the advanced PSN/MSN back to the QP context.
module tx_pkt_segmenter #(
   parameter int MAX_QP       = 256,
   parameter int QP_PTR_WIDTH = $clog2(MAX_QP)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_wqe_valid,
   output logic                    o_wqe_ready,
   input  logic [QP_PTR_WIDTH-1:0] i_wqe_qp_id,
   input  logic [31:0]             i_wqe_len,
   output logic                    o_qpc_hdr_lookup_valid,
   input  logic                    i_qpc_hdr_lookup_ready,
   output logic [QP_PTR_WIDTH-1:0] o_qpc_hdr_lookup_qp_id,
   input  logic                    i_qpc_valid,
   input  logic [2:0]              i_qpc_pmtu,
   input  logic [23:0]             i_qpc_sq_curr_psn,
   input  logic [23:0]             i_qpc_sq_curr_msn,
   output logic                    o_pkt_valid,
   input  logic                    i_pkt_ready,
   output logic [QP_PTR_WIDTH-1:0] o_pkt_qp_id,
   output logic [23:0]             o_pkt_psn,
   output logic [1:0]              o_pkt_opcode,
   output logic [12:0]             o_pkt_len,
   output logic                    o_pkt_ack_req,
   output logic                    o_qpc_hdr_update_valid,
   output logic [QP_PTR_WIDTH-1:0] o_qpc_hdr_update_qpid,
   output logic [23:0]             o_qpc_sq_curr_psn,
   output logic [23:0]             o_qpc_sq_curr_msn
);

   typedef enum logic [2:0] {IDLE, LOOKUP, WAIT_QPC, SEND, UPDATE} state_t;

   localparam logic [1:0] OP_FIRST  = 2'b00;
   localparam logic [1:0] OP_MIDDLE = 2'b01;
   localparam logic [1:0] OP_LAST   = 2'b10;
   localparam logic [1:0] OP_ONLY   = 2'b11;

   state_t                  state;
   logic [QP_PTR_WIDTH-1:0] qp_id;
   logic [31:0]             rem;
   logic [12:0]             mtu;
   logic [23:0]             msn;

   function automatic logic [12:0] mtu_decode(input logic [2:0] code);
      case (code)
         3'd2:    return 13'd512;
         3'd3:    return 13'd1024;
         3'd4:    return 13'd2048;
         3'd5:    return 13'd4096;
         default: return 13'd256;
      endcase
   endfunction

   // rem <= m bounds rem to 4096, so the low 13 bits hold it exactly
   function automatic logic [12:0] seg_len(input logic [31:0] r, input logic [12:0] m);
      return (r <= {19'd0, m}) ? r[12:0] : m;
   endfunction

   logic [12:0] qpc_mtu;
   logic [31:0] rem_after;
   logic        pkt_fire;
   logic        pkt_last;

   assign qpc_mtu   = mtu_decode(i_qpc_pmtu);
   assign rem_after = rem - {19'd0, o_pkt_len};
   assign pkt_fire  = o_pkt_valid && i_pkt_ready;
   assign pkt_last  = o_pkt_opcode[1];

   always_ff @(posedge clk) begin
      if (rst) begin
         state                  <= IDLE;
         qp_id                  <= '0;
         rem                    <= '0;
         mtu                    <= '0;
         msn                    <= '0;
         o_wqe_ready            <= 1'b0;
         o_qpc_hdr_lookup_valid <= 1'b0;
         o_qpc_hdr_lookup_qp_id <= '0;
         o_pkt_valid            <= 1'b0;
         o_pkt_qp_id            <= '0;
         o_pkt_psn              <= '0;
         o_pkt_opcode           <= '0;
         o_pkt_len              <= '0;
         o_pkt_ack_req          <= 1'b0;
         o_qpc_hdr_update_valid <= 1'b0;
         o_qpc_hdr_update_qpid  <= '0;
         o_qpc_sq_curr_psn      <= '0;
         o_qpc_sq_curr_msn      <= '0;
      end else begin
         o_qpc_hdr_update_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (i_wqe_valid && o_wqe_ready) begin
                  qp_id                  <= i_wqe_qp_id;
                  rem                    <= i_wqe_len;
                  o_wqe_ready            <= 1'b0;
                  o_qpc_hdr_lookup_valid <= 1'b1;
                  o_qpc_hdr_lookup_qp_id <= i_wqe_qp_id;
                  state                  <= LOOKUP;
               end else begin
                  o_wqe_ready <= 1'b1;
               end
            end
            LOOKUP: begin
               if (i_qpc_hdr_lookup_ready) begin
                  o_qpc_hdr_lookup_valid <= 1'b0;
                  state                  <= WAIT_QPC;
               end
            end
            WAIT_QPC: begin
               // First descriptor is built straight from the context response
               if (i_qpc_valid) begin
                  mtu         <= qpc_mtu;
                  msn         <= i_qpc_sq_curr_msn;
                  o_pkt_valid <= 1'b1;
                  o_pkt_qp_id <= qp_id;
                  o_pkt_psn   <= i_qpc_sq_curr_psn;
                  o_pkt_len   <= seg_len(rem, qpc_mtu);
                  if (rem <= {19'd0, qpc_mtu}) begin
                     o_pkt_opcode  <= OP_ONLY;
                     o_pkt_ack_req <= 1'b1;
                  end else begin
                     o_pkt_opcode  <= OP_FIRST;
                     o_pkt_ack_req <= 1'b0;
                  end
                  state <= SEND;
               end
            end
            SEND: begin
               if (pkt_fire) begin
                  rem <= rem_after;
                  if (pkt_last) begin
                     o_pkt_valid            <= 1'b0;
                     o_qpc_hdr_update_valid <= 1'b1;
                     o_qpc_hdr_update_qpid  <= qp_id;
                     o_qpc_sq_curr_psn      <= o_pkt_psn + 24'd1;
                     o_qpc_sq_curr_msn      <= msn + 24'd1;
                     state                  <= UPDATE;
                  end else begin
                     o_pkt_psn <= o_pkt_psn + 24'd1;
                     o_pkt_len <= seg_len(rem_after, mtu);
                     if (rem_after <= {19'd0, mtu}) begin
                        o_pkt_opcode  <= OP_LAST;
                        o_pkt_ack_req <= 1'b1;
                     end else begin
                        o_pkt_opcode  <= OP_MIDDLE;
                        o_pkt_ack_req <= 1'b0;
                     end
                  end
               end
            end
            UPDATE: begin
               o_wqe_ready <= 1'b1;
               state       <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tx_pkt_segmenter.sv
// Bench for tx_pkt_segmenter: directed scenarios plus randomized messages
// checked against a per-message arithmetic model of the packet sequence.
module tb_tx_pkt_segmenter;
   localparam int MAX_QP = 256;
   localparam int QPW    = $clog2(MAX_QP);

   logic           clk = 1'b0;
   logic           rst;
   logic           i_wqe_valid;
   logic           o_wqe_ready;
   logic [QPW-1:0] i_wqe_qp_id;
   logic [31:0]    i_wqe_len;
   logic           o_qpc_hdr_lookup_valid;
   logic           i_qpc_hdr_lookup_ready;
   logic [QPW-1:0] o_qpc_hdr_lookup_qp_id;
   logic           i_qpc_valid;
   logic [2:0]     i_qpc_pmtu;
   logic [23:0]    i_qpc_sq_curr_psn;
   logic [23:0]    i_qpc_sq_curr_msn;
   logic           o_pkt_valid;
   logic           i_pkt_ready;
   logic [QPW-1:0] o_pkt_qp_id;
   logic [23:0]    o_pkt_psn;
   logic [1:0]     o_pkt_opcode;
   logic [12:0]    o_pkt_len;
   logic           o_pkt_ack_req;
   logic           o_qpc_hdr_update_valid;
   logic [QPW-1:0] o_qpc_hdr_update_qpid;
   logic [23:0]    o_qpc_sq_curr_psn;
   logic [23:0]    o_qpc_sq_curr_msn;

   always #5 clk = ~clk;

   tx_pkt_segmenter #(.MAX_QP(MAX_QP)) dut (
      .clk                    (clk),
      .rst                    (rst),
      .i_wqe_valid            (i_wqe_valid),
      .o_wqe_ready            (o_wqe_ready),
      .i_wqe_qp_id            (i_wqe_qp_id),
      .i_wqe_len              (i_wqe_len),
      .o_qpc_hdr_lookup_valid (o_qpc_hdr_lookup_valid),
      .i_qpc_hdr_lookup_ready (i_qpc_hdr_lookup_ready),
      .o_qpc_hdr_lookup_qp_id (o_qpc_hdr_lookup_qp_id),
      .i_qpc_valid            (i_qpc_valid),
      .i_qpc_pmtu             (i_qpc_pmtu),
      .i_qpc_sq_curr_psn      (i_qpc_sq_curr_psn),
      .i_qpc_sq_curr_msn      (i_qpc_sq_curr_msn),
      .o_pkt_valid            (o_pkt_valid),
      .i_pkt_ready            (i_pkt_ready),
      .o_pkt_qp_id            (o_pkt_qp_id),
      .o_pkt_psn              (o_pkt_psn),
      .o_pkt_opcode           (o_pkt_opcode),
      .o_pkt_len              (o_pkt_len),
      .o_pkt_ack_req          (o_pkt_ack_req),
      .o_qpc_hdr_update_valid (o_qpc_hdr_update_valid),
      .o_qpc_hdr_update_qpid  (o_qpc_hdr_update_qpid),
      .o_qpc_sq_curr_psn      (o_qpc_sq_curr_psn),
      .o_qpc_sq_curr_msn      (o_qpc_sq_curr_msn)
   );

   int vectors     = 0;
   int miscompares = 0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic longint mtu_of(input logic [2:0] code);
      case (code)
         3'd2:    return 512;
         3'd3:    return 1024;
         3'd4:    return 2048;
         3'd5:    return 4096;
         default: return 256;
      endcase
   endfunction

   function automatic longint npkts_of(input logic [31:0] len, input logic [2:0] pmtu);
      longint l = longint'(len);
      longint m = mtu_of(pmtu);
      return (l == 0) ? 1 : (l + m - 1) / m;
   endfunction

   // Expected descriptor {qp, psn, opcode, len, ack_req} for packet idx
   function automatic logic [127:0] exp_desc(input logic [QPW-1:0] qp, input logic [31:0] len,
                                             input logic [2:0] pmtu, input logic [23:0] psn0,
                                             input longint idx);
      longint      m = mtu_of(pmtu);
      longint      n = npkts_of(len, pmtu);
      longint      plen;
      logic [1:0]  op;
      logic [12:0] l13;
      logic [23:0] p;
      plen = (idx == n - 1) ? longint'(len) - (n - 1) * m : m;
      if (n == 1)           op = 2'b11;
      else if (idx == 0)    op = 2'b00;
      else if (idx == n - 1) op = 2'b10;
      else                  op = 2'b01;
      l13 = 13'(plen);
      p   = 24'(longint'(psn0) + idx);
      return 128'({qp, p, op, l13, op[1]});
   endfunction

   function automatic logic [127:0] desc_now();
      return 128'({o_pkt_qp_id, o_pkt_psn, o_pkt_opcode, o_pkt_len, o_pkt_ack_req});
   endfunction

   function automatic logic [127:0] all_outs();
      return 128'({o_wqe_ready, o_qpc_hdr_lookup_valid, o_qpc_hdr_lookup_qp_id, o_pkt_valid,
                   o_pkt_qp_id, o_pkt_psn, o_pkt_opcode, o_pkt_len, o_pkt_ack_req,
                   o_qpc_hdr_update_valid, o_qpc_hdr_update_qpid, o_qpc_sq_curr_psn,
                   o_qpc_sq_curr_msn});
   endfunction

   task automatic garbage_qpc(input bit strobe);
      i_qpc_valid       = strobe;
      i_qpc_pmtu        = 3'($urandom);
      i_qpc_sq_curr_psn = 24'($urandom);
      i_qpc_sq_curr_msn = 24'($urandom);
   endtask

   // One complete message; rdy_mode 0=always ready, 1=toggle, 2=random.
   // abort_after >= 0 asserts rst once that many packets have been accepted.
   task automatic run_msg(input logic [QPW-1:0] qp, input logic [31:0] len, input logic [2:0] pmtu,
                          input logic [23:0] psn0, input logic [23:0] msn0, input int rdy_mode,
                          input int lk_dly, input int qpc_dly, input bit hold_wqe,
                          input int abort_after);
      longint       n = npkts_of(len, pmtu);
      longint       idx = 0;
      int           cyc = 0;
      int           w = 0;
      bit           r;
      bit           prev_stall = 0;
      logic [127:0] prev_desc = '0;

      while (o_wqe_ready !== 1'b1 && w < 20) begin
         tick();
         w++;
      end
      check("wqe_ready_before_offer", 128'(o_wqe_ready), 128'(1));
      i_wqe_valid = 1'b1;
      i_wqe_qp_id = qp;
      i_wqe_len   = len;
      tick();
      if (!hold_wqe) i_wqe_valid = 1'b0;
      i_wqe_qp_id = QPW'($urandom);
      i_wqe_len   = $urandom;

      for (int d = 0; d <= lk_dly; d++) begin
         check("lookup_req", 128'({o_qpc_hdr_lookup_valid, o_qpc_hdr_lookup_qp_id}),
               128'({1'b1, qp}));
         check("wqe_ready_busy_lookup", 128'(o_wqe_ready), 128'(0));
         i_qpc_hdr_lookup_ready = (d == lk_dly);
         garbage_qpc(1'($urandom));
         tick();
      end
      i_qpc_hdr_lookup_ready = 1'b0;

      for (int d = 0; d <= qpc_dly; d++) begin
         check("wait_qpc_quiet", 128'({o_qpc_hdr_lookup_valid, o_pkt_valid}), 128'(0));
         if (d == qpc_dly) begin
            i_qpc_valid       = 1'b1;
            i_qpc_pmtu        = pmtu;
            i_qpc_sq_curr_psn = psn0;
            i_qpc_sq_curr_msn = msn0;
         end else begin
            garbage_qpc(1'b0);
         end
         tick();
      end

      while (idx < n && cyc < int'(n) * 8 + 50) begin
         if (abort_after >= 0 && idx == longint'(abort_after)) begin
            check("abort_desc", desc_now(), exp_desc(qp, len, pmtu, psn0, idx));
            rst         = 1'b1;
            i_pkt_ready = 1'b0;
            i_wqe_valid = 1'b0;
            tick();
            check("abort_reset_outs_1", all_outs(), 128'(0));
            tick();
            check("abort_reset_outs_2", all_outs(), 128'(0));
            rst = 1'b0;
            tick();
            check("abort_after_release", 128'({o_wqe_ready, o_qpc_hdr_update_valid, o_pkt_valid}),
                  128'(3'b100));
            i_qpc_valid = 1'b0;
            return;
         end
         if (prev_stall)
            check("stall_stable", desc_now(), prev_desc);
         check("pkt_valid_in_send", 128'(o_pkt_valid), 128'(1));
         check("wqe_ready_busy_send", 128'(o_wqe_ready), 128'(0));
         case (rdy_mode)
            0:       r = 1'b1;
            1:       r = (cyc % 2 == 0);
            default: r = 1'($urandom);
         endcase
         i_pkt_ready = r;
         if (o_pkt_valid && r) begin
            check($sformatf("pkt_desc[%0d]", idx), desc_now(), exp_desc(qp, len, pmtu, psn0, idx));
            idx++;
         end
         prev_stall = o_pkt_valid && !r;
         prev_desc  = desc_now();
         garbage_qpc(1'($urandom));
         tick();
         cyc++;
      end
      if (idx < n) check("pkt_count_timeout", 128'(idx), 128'(n));
      if (rdy_mode == 0) check("no_bubble_cycles", 128'(cyc), 128'(n));
      i_pkt_ready = 1'b0;
      i_qpc_valid = 1'b0;

      check("update_strobe", 128'({o_qpc_hdr_update_valid, o_pkt_valid, o_wqe_ready}),
            128'(3'b100));
      check("update_fields",
            128'({o_qpc_hdr_update_qpid, o_qpc_sq_curr_psn, o_qpc_sq_curr_msn}),
            128'({qp, 24'(longint'(psn0) + n), 24'(msn0 + 24'd1)}));
      tick();
      check("update_one_cycle_then_ready", 128'({o_qpc_hdr_update_valid, o_wqe_ready}),
            128'(2'b01));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] len;
      logic [2:0]  pm;
      logic [23:0] psn;
      int          m;

      rst = 1'b1;
      i_wqe_valid = 1'b0;
      i_wqe_qp_id = '0;
      i_wqe_len = '0;
      i_qpc_hdr_lookup_ready = 1'b0;
      i_qpc_valid = 1'b0;
      i_qpc_pmtu = '0;
      i_qpc_sq_curr_psn = '0;
      i_qpc_sq_curr_msn = '0;
      i_pkt_ready = 1'b0;
      tick();
      tick();
      tick();
      check("reset_outputs", all_outs(), 128'(0));
      rst = 1'b0;
      tick();
      check("ready_after_reset", 128'(o_wqe_ready), 128'(1));

      run_msg(8'd5,  32'd1000, 3'd3, 24'd10,       24'd5,       0, 0, 0, 1'b0, -1);
      run_msg(8'd17, 32'd5000, 3'd2, 24'd100,      24'd7,       0, 0, 0, 1'b0, -1);
      run_msg(8'd3,  32'd0,    3'd4, 24'd20,       24'hFFFFFF,  0, 1, 2, 1'b0, -1);
      run_msg(8'd9,  32'd1024, 3'd1, 24'hFFFFFE,   24'd44,      0, 0, 0, 1'b0, -1);
      run_msg(8'd33, 32'd5000, 3'd2, 24'd500,      24'd1,       1, 0, 1, 1'b1, -1);
      run_msg(8'd34, 32'd300,  3'd7, 24'd900,      24'd2,       1, 2, 0, 1'b0, -1);
      run_msg(8'd77, 32'd600,  3'd1, 24'd1234,     24'd3,       0, 0, 0, 1'b0, 1);
      run_msg(8'd78, 32'h0001_0010, 3'd5, 24'hFFFFF8, 24'd9,    2, 0, 0, 1'b0, -1);
      run_msg(8'd79, 32'd4096, 3'd5, 24'd0,        24'd0,       0, 0, 0, 1'b0, -1);
      run_msg(8'd80, 32'd4097, 3'd0, 24'd7,        24'd8,       2, 3, 3, 1'b0, -1);

      for (int k = 0; k < 25; k++) begin
         pm = 3'($urandom);
         m  = int'(mtu_of(pm));
         case ($urandom_range(0, 3))
            0:       len = 32'($urandom_range(0, 1));
            1:       len = 32'(m * $urandom_range(1, 6));
            2:       len = 32'($urandom_range(1, 3 * m));
            default: len = 32'($urandom_range(1, 12000));
         endcase
         psn = ($urandom_range(0, 3) == 0) ? 24'hFFFFFF - 24'($urandom_range(0, 4))
                                           : 24'($urandom);
         run_msg(QPW'($urandom), len, pm, psn, 24'($urandom), int'($urandom_range(0, 2)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom),
                 ($urandom_range(0, 7) == 0) ? 0 : -1);
         i_wqe_valid = 1'b0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
